// File: rtl/joy_pkg.sv
// joy_cursor_accel shared types: zone/FSM enums, zone classifier and
// the saturating step-and-clamp helper used by both axes.
package joy_pkg;

  typedef enum logic [2:0] {
    CENTER, NEAR_LO, FAR_LO, NEAR_HI, FAR_HI
  } zone_e;

  typedef enum logic [1:0] {
    IDLE, MOVE, TURBO
  } st_e;

  function automatic zone_e classify(
    input int v, input int fl, input int nl,
    input int nh, input int fh
  );
    if (v < fl) return FAR_LO;
    if (v < nl) return NEAR_LO;
    if (v > fh) return FAR_HI;
    if (v > nh) return NEAR_HI;
    return CENTER;
  endfunction

  function automatic int clamp_step(
    input int pos, input int step, input logic up,
    input int lb, input int ub
  );
    int s;
    s = up ? pos + step : pos - step;
    if (s < lb) return lb;
    if (s > ub) return ub;
    return s;
  endfunction

endpackage

// File: rtl/joy_cursor_accel_axis.sv
// One cursor axis: zone classification, hold-to-accelerate FSM and
// clamped position register. pos_d is the value pos takes next edge.
import joy_pkg::*;

module joy_axis #(
  parameter int W           = 10,
  parameter int JW          = 10,
  parameter int INIT        = 0,
  parameter int LB          = 0,
  parameter int UB          = 1023,
  parameter int TH_FAR_LO   = 150,
  parameter int TH_NEAR_LO  = 400,
  parameter int TH_NEAR_HI  = 600,
  parameter int TH_FAR_HI   = 850,
  parameter int STEP_SLOW   = 10,
  parameter int STEP_FAST   = 20,
  parameter int STEP_MAX    = 40,
  parameter int ACCEL_TICKS = 8,
  parameter bit INV         = 0
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          rst,
  input  logic          upd,
  input  logic [JW-1:0] joy,
  output logic [W-1:0]  pos,
  output logic [W-1:0]  pos_d
);

  localparam int CW = $clog2(ACCEL_TICKS) + 1;

  st_e          st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic         dir, dir_n;
  zone_e        zn;
  logic         far, lo, dpos;
  int           step, zstep;

  always_comb begin
    zn    = classify(int'(joy), TH_FAR_LO, TH_NEAR_LO,
                     TH_NEAR_HI, TH_FAR_HI);
    far   = (zn == FAR_LO) || (zn == FAR_HI);
    lo    = (zn == FAR_LO) || (zn == NEAR_LO);
    dpos  = lo ? INV : !INV;
    zstep = far ? STEP_FAST : STEP_SLOW;
    st_n  = st;
    cnt_n = cnt;
    dir_n = dir;
    step  = 0;
    if (zn == CENTER) begin
      st_n  = IDLE;
      cnt_n = '0;
    end else begin
      unique case (st)
        IDLE: begin
          st_n  = MOVE;
          cnt_n = CW'(1);
          dir_n = dpos;
          step  = zstep;
        end
        MOVE: begin
          if (dpos != dir) begin
            cnt_n = CW'(1);
            dir_n = dpos;
            step  = zstep;
          end else if (far && cnt == CW'(ACCEL_TICKS - 1)) begin
            st_n = TURBO;
            step = STEP_MAX;
          end else begin
            if (!far)
              cnt_n = '0;
            else if (cnt != {CW{1'b1}})
              cnt_n = cnt + CW'(1);
            step = zstep;
          end
        end
        default: begin
          if (dpos != dir) begin
            st_n  = MOVE;
            cnt_n = CW'(1);
            dir_n = dpos;
            step  = zstep;
          end else if (far) begin
            step = STEP_MAX;
          end else begin
            st_n  = MOVE;
            cnt_n = '0;
            step  = STEP_SLOW;
          end
        end
      endcase
    end
    pos_d = upd ? W'(clamp_step(int'(pos), step, dir_n, LB, UB))
                : pos;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st  <= IDLE;
      cnt <= '0;
      dir <= 1'b0;
      pos <= W'(INIT);
    end else if (rst) begin
      st  <= IDLE;
      cnt <= '0;
      dir <= 1'b0;
      pos <= W'(INIT);
    end else if (upd) begin
      st  <= st_n;
      cnt <= cnt_n;
      dir <= dir_n;
      pos <= pos_d;
    end
  end

endmodule

// File: rtl/joy_cursor_accel.sv
// Two-axis joystick cursor engine: tick edge detect, per-axis
// accelerating stepper, move pulse and registered bound flags.
import joy_pkg::*;

module joy_cursor_accel #(
  parameter int W           = 10,
  parameter int JW          = 10,
  parameter int INIT_X      = 724,
  parameter int INIT_Y      = 271,
  parameter int X_LB        = 574,
  parameter int X_UB        = 734,
  parameter int Y_LB        = 71,
  parameter int Y_UB        = 471,
  parameter int TH_FAR_LO   = 150,
  parameter int TH_NEAR_LO  = 400,
  parameter int TH_NEAR_HI  = 600,
  parameter int TH_FAR_HI   = 850,
  parameter int STEP_SLOW   = 10,
  parameter int STEP_FAST   = 20,
  parameter int STEP_MAX    = 40,
  parameter int ACCEL_TICKS = 8,
  parameter bit INV_X       = 1,
  parameter bit INV_Y       = 0
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          rst,
  input  logic          tick,
  input  logic [JW-1:0] joy_x,
  input  logic [JW-1:0] joy_y,
  output logic [W-1:0]  dot_x,
  output logic [W-1:0]  dot_y,
  output logic          moved,
  output logic [3:0]    at_edge
);

  logic         tick_q, upd;
  logic [W-1:0] x_d, y_d;

  assign upd = tick & ~tick_q;

  joy_axis #(
    .W(W), .JW(JW), .INIT(INIT_X), .LB(X_LB), .UB(X_UB),
    .TH_FAR_LO(TH_FAR_LO), .TH_NEAR_LO(TH_NEAR_LO),
    .TH_NEAR_HI(TH_NEAR_HI), .TH_FAR_HI(TH_FAR_HI),
    .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST),
    .STEP_MAX(STEP_MAX), .ACCEL_TICKS(ACCEL_TICKS), .INV(INV_X)
  ) u_x (
    .clk(clk), .clr(clr), .rst(rst), .upd(upd),
    .joy(joy_x), .pos(dot_x), .pos_d(x_d)
  );

  joy_axis #(
    .W(W), .JW(JW), .INIT(INIT_Y), .LB(Y_LB), .UB(Y_UB),
    .TH_FAR_LO(TH_FAR_LO), .TH_NEAR_LO(TH_NEAR_LO),
    .TH_NEAR_HI(TH_NEAR_HI), .TH_FAR_HI(TH_FAR_HI),
    .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST),
    .STEP_MAX(STEP_MAX), .ACCEL_TICKS(ACCEL_TICKS), .INV(INV_Y)
  ) u_y (
    .clk(clk), .clr(clr), .rst(rst), .upd(upd),
    .joy(joy_y), .pos(dot_y), .pos_d(y_d)
  );

  localparam logic [3:0] EDGE_INIT = {
    INIT_X == X_LB, INIT_X == X_UB,
    INIT_Y == Y_LB, INIT_Y == Y_UB
  };

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tick_q  <= 1'b0;
      moved   <= 1'b0;
      at_edge <= EDGE_INIT;
    end else if (rst) begin
      tick_q  <= 1'b0;
      moved   <= 1'b0;
      at_edge <= EDGE_INIT;
    end else begin
      tick_q  <= tick;
      moved   <= (x_d != dot_x) || (y_d != dot_y);
      at_edge <= {x_d == W'(X_LB), x_d == W'(X_UB),
                  y_d == W'(Y_LB), y_d == W'(Y_UB)};
    end
  end

endmodule

// File: tb/tb_joy_cursor_accel.sv
// Directed self-checking bench for joy_cursor_accel with
// hand-computed positions, pulses and edge flags.
import joy_pkg::*;

module tb_joy_cursor_accel;

  logic       clk = 1'b0;
  logic       clr, rst, tick;
  logic [9:0] joy_x, joy_y;
  logic [9:0] dot_x, dot_y;
  logic       moved;
  logic [3:0] at_edge;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  joy_cursor_accel dut (
    .clk(clk), .clr(clr), .rst(rst), .tick(tick),
    .joy_x(joy_x), .joy_y(joy_y),
    .dot_x(dot_x), .dot_y(dot_y),
    .moved(moved), .at_edge(at_edge)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic pulse_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk);
  endtask

  task automatic end_tick();
    tick = 1'b0;
    @(negedge clk);
    chk("moved_drop", moved, 0);
  endtask

  int ys_far[10] = '{251, 231, 211, 191, 171, 151, 131, 91, 71, 71};
  int ys_up[8]   = '{291, 311, 331, 351, 371, 391, 411, 451};
  int pulses;

  initial begin
    clr = 1'b1; rst = 1'b0; tick = 1'b0;
    joy_x = 10'd500; joy_y = 10'd500;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    chk("rst_x", dot_x, 724);
    chk("rst_y", dot_y, 271);
    chk("rst_moved", moved, 0);
    chk("rst_edge", at_edge, 4'b0000);

    joy_y = 10'd100;
    for (int i = 0; i < 10; i++) begin
      pulse_tick();
      chk("far_y", dot_y, ys_far[i]);
      chk("far_moved", moved, (i == 9) ? 0 : 1);
      if (i >= 8) chk("far_edge", at_edge, 4'b0010);
      end_tick();
    end

    #3 clr = 1'b1;
    #1;
    chk("clr_x", dot_x, 724);
    chk("clr_y", dot_y, 271);
    chk("clr_moved", moved, 0);
    chk("clr_edge", at_edge, 4'b0000);
    chk("clr_sty", dut.u_y.st, IDLE);
    @(negedge clk) clr = 1'b0;

    joy_y = 10'd500; joy_x = 10'd100;
    pulse_tick();
    chk("xhi_x", dot_x, 734);
    chk("xhi_moved", moved, 1);
    chk("xhi_edge", at_edge, 4'b0100);
    end_tick();
    pulse_tick();
    chk("xhi2_x", dot_x, 734);
    chk("xhi2_moved", moved, 0);
    end_tick();

    joy_x = 10'd500; joy_y = 10'd100;
    pulse_tick();
    chk("pre_rst_y", dot_y, 251);
    tick = 1'b0;
    @(negedge clk) rst = 1'b1;
    chk("rst_hold_y", dot_y, 251);
    @(negedge clk) rst = 1'b0;
    chk("srst_x", dot_x, 724);
    chk("srst_y", dot_y, 271);
    chk("srst_moved", moved, 0);
    chk("srst_edge", at_edge, 4'b0000);

    joy_y = 10'd900;
    for (int i = 0; i < 8; i++) begin
      pulse_tick();
      chk("up_y", dot_y, ys_up[i]);
      end_tick();
    end
    chk("up_st", dut.u_y.st, TURBO);
    joy_y = 10'd100;
    pulse_tick();
    chk("rev_y", dot_y, 431);
    chk("rev_st", dut.u_y.st, MOVE);
    end_tick();

    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    joy_x = 10'd500; joy_y = 10'd500;
    for (int i = 0; i < 5; i++) begin
      pulse_tick();
      chk("ctr_x", dot_x, 724);
      chk("ctr_y", dot_y, 271);
      chk("ctr_moved", moved, 0);
      end_tick();
    end
    chk("ctr_stx", dut.u_x.st, IDLE);
    chk("ctr_sty", dut.u_y.st, IDLE);

    joy_y = 10'd300;
    pulses = 0;
    @(negedge clk) tick = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (moved) pulses++;
    end
    tick = 1'b0;
    chk("hold_pulses", pulses, 1);
    chk("hold_y", dot_y, 261);
    @(negedge clk);
    chk("hold_moved", moved, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/joy_cursor_accel.md
Name: joy_cursor_accel

Overview:
- Two-axis joystick-to-cursor position engine; successor of the fixed-step cursor updater.
- Sits between the joystick sampler (10-bit ADC readings) and the VGA sprite/overlay logic.
- Adds parametrised widths, thresholds, steps, bounds and axis polarity.
- Adds an internal cursor-tick edge detector, hold-to-accelerate state machine per axis, saturating bound clamping, and move/edge status outputs.

Parameters:
- W, 10, coordinate width.
- JW, 10, joystick sample width.
- INIT_X, 724; INIT_Y, 271: reset position.
- X_LB, 574; X_UB, 734; Y_LB, 71; Y_UB, 471: inclusive clamp bounds.
- TH_FAR_LO, 150; TH_NEAR_LO, 400; TH_NEAR_HI, 600; TH_FAR_HI, 850: zone thresholds.
- STEP_SLOW, 10; STEP_FAST, 20; STEP_MAX, 40: step sizes.
- ACCEL_TICKS, 8: consecutive far-zone ticks before turbo; must be at least 2.
- INV_X, 1; INV_Y, 0: when 1, a low joystick value gives a positive direction.

Ports:
- clk  in  1  system clock
- clr  in  1  asynchronous active-high reset
- rst  in  1  synchronous active-high reset; same values as clr
- tick  in  1  cursor-rate clock (slow, level); rising edge detected internally
- joy_x  in  JW  joystick X sample
- joy_y  in  JW  joystick Y sample
- dot_x  out  W  cursor X
- dot_y  out  W  cursor Y
- moved  out  1  one-cycle pulse: position changed on this update
- at_edge  out  4  {x_lo, x_hi, y_lo, y_hi}: registered, high when the coordinate equals its bound

Behaviour:
- Reset (clr async, or rst at clk edge):
  - dot_x=INIT_X, dot_y=INIT_Y, moved=0.
  - at_edge is computed from INIT values.
  - Both axis FSMs go to IDLE, counters to 0, tick_q to 0.
- tick_q <= tick every clk. Update strobe upd = tick & ~tick_q.
  - Exactly one update per tick rising edge, however long tick stays high.
  - tick high out of reset: upd fires on the first clk edge after reset releases.
- Zone per axis (v = joystick value):
  - FAR_LO: v < TH_FAR_LO
  - NEAR_LO: v < TH_NEAR_LO
  - FAR_HI: v > TH_FAR_HI
  - NEAR_HI: v > TH_NEAR_HI
  - CENTER: otherwise
- Direction: dir = +1 for LO zones when INV=1, else -1; HI zones give the opposite sign.
- Axis FSM, evaluated only on upd. The step used is the one from the next state.
  - CENTER zone (any state): next=IDLE, cnt=0, step 0.
  - IDLE with non-center zone: next=MOVE, cnt=1, remember dir; step = FAST if far zone, else SLOW.
  - MOVE, same dir, far zone, cnt==ACCEL_TICKS-1: next=TURBO, step=STEP_MAX.
  - MOVE, same dir, any other case: cnt++ if far zone, else cnt=0; step as in IDLE.
  - TURBO, same dir, far zone: stay, step=STEP_MAX.
  - TURBO, same dir, near zone: next=MOVE, cnt=0, step=SLOW.
  - Direction reversal (MOVE or TURBO): next=MOVE, cnt=1, new dir, zone step.
  - cnt saturates; it never wraps.
- Arithmetic:
  - new = pos ± step, computed in W+2 bit signed.
  - Result is clamped to [LB, UB]; it never wraps.
  - A position already at a bound with dir pushing outward stays put; the FSM still advances.
- Timing and registered outputs:
  - dot_x/dot_y update at the same clk edge as upd (1 clk after the tick rise is sampled).
  - moved=1 for one clk after that edge iff dot_x or dot_y changed; otherwise 0.
  - at_edge is registered alongside dot.
- Joystick inputs are assumed already synchronous to clk.
- Reset during an update has priority; no partial update.

Decomposition:
- Package joy_pkg:
  - zone enum: CENTER, NEAR_LO, FAR_LO, NEAR_HI, FAR_HI
  - FSM enum: IDLE, MOVE, TURBO
  - shared clamp/step function
- Sub-module joy_axis (zone classify + FSM + clamp for one axis), instantiated twice with per-axis bounds, init and INV.
- Top level holds the tick edge detector, moved and at_edge.

Test Plan:
- Assert clr mid-sim -> dot=(724,271), moved=0, at_edge=0000 immediately without clk. Repeat with rst -> same values at the next clk.
- joy_y=100 (far, up), tick toggling 10 times with defaults -> dot_y 251, 231, …, 131 after 7 ticks; tick 8 -> 91 (turbo, 40); tick 9 -> clamps at 71; tick 10 -> stays 71, moved=0, y_lo=1.
- joy_x=100 from init -> tick 1: 744 clamps to 734, moved=1, x_hi=1; tick 2 -> 734, moved=0.
- joy_y=900 for 8 ticks (turbo), then joy_y=100 -> next step is -20 (MOVE, cnt=1), not -40.
- joy_x=500, joy_y=500 (center) across 5 ticks -> no change, moved never asserts, both FSMs IDLE.
- tick held high for 50 clk with joy_y=300 -> exactly one update (dot_y 271→261) and a single 1-clk moved pulse.
